button_event: RTL

- Downstream consumer of the debounced push-button level; turns it into single-cycle event strobes for the control FSMs: press, release, short click, long press and auto-repeat.
- One instance per debounced button.
- The input is already synchronised and glitch-free, so no synchroniser or debounce is done here.

---
 rtl/button_pkg.sv | 19 +
 rtl/tick_gen.sv | 31 +++
 rtl/button_event.sv | 124 ++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing constants for push-button event handling.
// Imported by the button event detector and its tick generator.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_t;

  localparam int TICK_1MS_50MHZ = 50000;
  localparam int LONG_MS        = 500;
  localparam int REPEAT_MS      = 100;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running time-base: tick is high for one cycle every TICK_CYCLES clocks.
// clear restarts the period so timing can be measured from an external event.
module tick_gen
  import button_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_1MS_50MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] tick_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tick_cnt_reg <= '0;
    end else if (tick_cnt_reg == TICK_LAST) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  assign tick = (tick_cnt_reg == TICK_LAST);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/click/long/repeat strobes.
// All strobes are registered and exactly one clock wide.
module button_event
  import button_pkg::*;
#(
  parameter int TICK_CYCLES  = TICK_1MS_50MHZ,
  parameter int LONG_TICKS   = LONG_MS,
  parameter int REPEAT_TICKS = REPEAT_MS,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int HOLD_MAX = max2(LONG_TICKS, REPEAT_TICKS);
  localparam int HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);

  logic       btn_q_reg;
  logic       rise;
  logic       fall;
  logic       tick;
  btn_state_t state_reg, state_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic press_reg, release_reg, click_reg, long_reg, repeat_reg;
  logic press_next, release_next, click_next, long_next, repeat_next;

  assign rise = btn_level & ~btn_q_reg;
  assign fall = ~btn_level & btn_q_reg;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(rise),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q_reg   <= 1'b0;
      state_reg   <= IDLE;
      hold_reg    <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      click_reg   <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;
    end else begin
      btn_q_reg   <= btn_level;
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      click_reg   <= click_next;
      long_reg    <= long_next;
      repeat_reg  <= repeat_next;
    end
  end

  // A rise in any state is treated as a fresh press; fall beats a coincident tick.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    if (rise) begin
      state_next = PRESSED;
      hold_next  = '0;
    end else begin
      unique case (state_reg)
        PRESSED: begin
          if (fall) begin
            state_next = IDLE;
          end else if (tick) begin
            if (hold_reg == LONG_LAST) begin
              state_next = LONG_HELD;
              hold_next  = '0;
            end else begin
              hold_next = hold_reg + 1'b1;
            end
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_next = IDLE;
          end else if (tick) begin
            if (hold_reg == REP_LAST) begin
              hold_next = '0;
            end else begin
              hold_next = hold_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    press_next   = rise;
    release_next = fall && (state_reg != IDLE);
    click_next   = fall && (state_reg == PRESSED);
    long_next    = !rise && !fall && tick && (state_reg == PRESSED) &&
                   (hold_reg == LONG_LAST);
    repeat_next  = (REPEAT_EN != 0) && !rise && !fall && tick &&
                   (state_reg == LONG_HELD) && (hold_reg == REP_LAST);
  end

  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign click_pulse   = click_reg;
  assign long_pulse    = long_reg;
  assign repeat_pulse  = repeat_reg;
  assign held          = btn_q_reg;

endmodule
